// File: rtl/cpu_pkg.sv
// cpu_pkg: constants and types shared by the fetch-side blocks.
//   INSTR_BYTES      - bytes per instruction word
//   OPC_*/ADR_*/OPD_* - bit positions of opcode, address/register and operand fields
//   NOP_WORD         - word delivered when a fetch is abandoned
//   fetch_state_t    - fetch FSM state encoding
package cpu_pkg;

  localparam int INSTR_BYTES = 3;

  localparam int OPC_HI = 23;
  localparam int OPC_LO = 16;
  localparam int ADR_HI = 15;
  localparam int ADR_LO = 8;
  localparam int OPD_HI = 7;
  localparam int OPD_LO = 0;

  localparam logic [23:0] NOP_WORD = 24'h000000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD0  = 2'd1,
    ST_RD1  = 2'd2,
    ST_RD2  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_watchdog.sv
// fetch_watchdog: counts consecutive cycles in which a memory request is
// outstanding but unacknowledged and flags the cycle in which the limit is hit.
//   clk, rst  - clock, asynchronous active-low reset
//   wait_cyc  - request high and ack low this cycle
//   timeout   - this is the TIMEOUT_CYC-th consecutive wait cycle
module fetch_watchdog #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic wait_cyc,
  output logic timeout
);

  localparam int CW = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_r;

  // Any acked or idle cycle restarts the count, so it measures one byte's wait only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= {CW{1'b0}};
    end else if (!wait_cyc || timeout) begin
      cnt_r <= {CW{1'b0}};
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  assign timeout = wait_cyc && (cnt_r == LAST);

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns PC and MAR and assembles a 24-bit instruction from
// three byte reads of program memory over a req/ack handshake.
//   Control strobes: MAR_load (start fetch), IR_load (consume fetched word),
//                    PC_inc (pc += 3), PC_en/PC_load (pc <= target)
//   Memory side:     mem_req/mem_addr out, mem_ack/mem_rdata in
//   Status:          pc, mar, command_word, ir_pending, fetch_busy, fetch_err
// Optional macro FETCH_TIMEOUT_EN adds a per-byte ack watchdog; a timed-out
// fetch delivers NOP_WORD and sets the sticky fetch_err flag.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MAR_load,
  input  logic        IR_load,
  input  logic        PC_inc,
  input  logic        PC_en,
  input  logic [7:0]  PC_load,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        mem_req,
  output logic [7:0]  mem_addr,
  output logic [7:0]  pc,
  output logic [7:0]  mar,
  output logic [23:0] command_word,
  output logic        ir_pending,
  output logic        fetch_busy,
  output logic        fetch_err
);

  fetch_state_t state_r;
  logic [7:0]   pc_r;
  logic [7:0]   mar_r;
  logic [7:0]   mem_addr_r;
  logic         mem_req_r;
  logic [23:0]  buf_r;
  logic [23:0]  command_word_r;
  logic         ir_pending_r;
  logic         busy_r;
  logic         fetch_err_r;
  logic         timeout_s;

`ifdef FETCH_TIMEOUT_EN
  logic wait_s;
  assign wait_s = mem_req_r & ~mem_ack;

  fetch_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .wait_cyc (wait_s),
    .timeout  (timeout_s)
  );
`else
  logic [31:0] unused_timeout_cfg_s;
  assign unused_timeout_cfg_s = TIMEOUT_CYC;
  assign timeout_s = 1'b0;
`endif

  // PC update, IR transfer and the byte-fetch sequencer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r        <= ST_IDLE;
      pc_r           <= 8'h00;
      mar_r          <= 8'h00;
      mem_addr_r     <= 8'h00;
      mem_req_r      <= 1'b0;
      buf_r          <= NOP_WORD;
      command_word_r <= 24'h000000;
      ir_pending_r   <= 1'b0;
      busy_r         <= 1'b0;
      fetch_err_r    <= 1'b0;
    end else begin
      if (PC_en) begin
        pc_r <= PC_load;
      end else if (PC_inc) begin
        pc_r <= pc_r + 8'(INSTR_BYTES);
      end else begin
        pc_r <= pc_r;
      end

      // ir_pending is low throughout a fetch, so IR_load on the final
      // capture edge cannot pick up the half-written buffer.
      if (IR_load && ir_pending_r) begin
        command_word_r <= buf_r;
        ir_pending_r   <= 1'b0;
      end

      case (state_r)
        ST_IDLE: begin
          if (MAR_load) begin
            state_r      <= ST_RD0;
            mar_r        <= pc_r;
            mem_addr_r   <= pc_r;
            mem_req_r    <= 1'b1;
            busy_r       <= 1'b1;
            ir_pending_r <= 1'b0;
          end
        end
        ST_RD0, ST_RD1, ST_RD2: begin
          if (timeout_s) begin
            state_r      <= ST_IDLE;
            mem_req_r    <= 1'b0;
            busy_r       <= 1'b0;
            buf_r        <= NOP_WORD;
            ir_pending_r <= 1'b1;
            fetch_err_r  <= 1'b1;
          end else if (mem_ack) begin
            case (state_r)
              ST_RD0: begin
                buf_r[OPC_HI:OPC_LO] <= mem_rdata;
                mem_addr_r           <= mem_addr_r + 8'd1;
                state_r              <= ST_RD1;
              end
              ST_RD1: begin
                buf_r[ADR_HI:ADR_LO] <= mem_rdata;
                mem_addr_r           <= mem_addr_r + 8'd1;
                state_r              <= ST_RD2;
              end
              ST_RD2: begin
                buf_r[OPD_HI:OPD_LO] <= mem_rdata;
                mem_req_r            <= 1'b0;
                busy_r               <= 1'b0;
                ir_pending_r         <= 1'b1;
                state_r              <= ST_IDLE;
              end
              default: begin
                state_r   <= ST_IDLE;
                mem_req_r <= 1'b0;
                busy_r    <= 1'b0;
              end
            endcase
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          mem_req_r <= 1'b0;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  assign pc           = pc_r;
  assign mar          = mar_r;
  assign mem_addr     = mem_addr_r;
  assign mem_req      = mem_req_r;
  assign command_word = command_word_r;
  assign ir_pending   = ir_pending_r;
  assign fetch_busy   = busy_r;
  assign fetch_err    = fetch_err_r;

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch unit answering the control unit's fetch-side strobes (`MAR_load`, `IR_load`, `PC_inc`, `PC_en`/`PC_load`). It owns the PC and MAR and reads each 24-bit instruction as three bytes from an 8-bit program memory over a req/ack handshake. It delivers the instruction as `command_word`: `[23:16]` opcode, `[15:8]` address/register, `[7:0]` operand. It sits between the control unit and program memory.

## Interface
- `TIMEOUT_CYC`, 16: max wait cycles for `mem_ack` per byte (used only with the timeout macro).
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `MAR_load` in 1: launch a fetch from the current PC.
- `IR_load` in 1: transfer the pending fetched instruction into `command_word`.
- `PC_inc` in 1: PC += 3.
- `PC_en` in 1: PC <= `PC_load`.
- `PC_load` in 8: jump/return target.
- `mem_ack` in 1: memory has valid `mem_rdata` this cycle.
- `mem_rdata` in 8: program memory byte.
- `mem_req` out 1: read request.
- `mem_addr` out 8: byte address, stable while `mem_req` is high.
- `pc` out 8: program counter.
- `mar` out 8: base address of the current or last fetch.
- `command_word` out 24: instruction register.
- `ir_pending` out 1: fetched instruction waiting for `IR_load`.
- `fetch_busy` out 1: fetch FSM is not in IDLE.
- `fetch_err` out 1: sticky timeout flag.

## Operation
- Reset value of every output is 0: `pc`, `mar`, `command_word`, all flags, `mem_req`, `mem_addr`. The FSM resets to IDLE.
- PC update, each edge:
  - `PC_en`=1: `pc` <= `PC_load`. `PC_en` has priority over `PC_inc`.
  - else `PC_inc`=1: `pc` <= `pc`+3, mod 256 (0xFE+3 = 0x01).
  - else hold.
- FSM states:
  - IDLE: `MAR_load`=1 → RD0. At the same time, `mar` <= `pc` (value before any same-edge PC update), `mem_addr` <= `pc`, `mem_req` <= 1, and `ir_pending` <= 0 (any unconsumed instruction is discarded).
  - RD0 / RD1 / RD2: the byte is captured on the edge where `mem_ack`=1.
    - RD0 captures buffer `[23:16]`; RD1 captures `[15:8]`; RD2 captures `[7:0]`.
    - After the RD0 and RD1 captures, `mem_addr` <= `mem_addr`+1 (mod 256) and `mem_req` stays high.
    - After the RD2 capture, `mem_req` <= 0, `ir_pending` <= 1, and the FSM returns to IDLE.
- `MAR_load` while busy is ignored.
- `IR_load`=1 with `ir_pending`=1: `command_word` <= buffer and `ir_pending` <= 0.
- `IR_load` with `ir_pending`=0 is ignored. `command_word` holds through repeated `IR_load` during execution states.
- `IR_load` on the same edge as the RD2 capture is ignored; the instruction is consumable from the next cycle.
- PC strobes never affect an in-flight fetch; `mar` and `mem_addr` stay frozen.
- Reset asserted mid-fetch: immediately returns to IDLE with all outputs 0. No partial word is ever visible.

## Timing
- Zero-wait memory (`mem_ack` high in every `mem_req` cycle): `MAR_load` sampled at edge k → bytes captured at k+1, k+2, k+3 → `ir_pending`=1 after k+3 → earliest `command_word` update at k+4.
- Each wait cycle (`mem_req`=1, `mem_ack`=0) adds one cycle to that byte.
- `mem_ack` while `mem_req`=0 is ignored.
- `fetch_busy` is high from edge k through edge k+3 (exclusive of the following IDLE cycle).

## Configuration
- `FETCH_TIMEOUT_EN` defined:
  - A per-byte wait counter resets on each capture.
  - When `TIMEOUT_CYC` consecutive cycles pass with `mem_req`=1 and `mem_ack`=0, the fetch aborts: `mem_req` <= 0, buffer <= 24'h000000 (NOP), `ir_pending` <= 1, `fetch_err` <= 1, FSM → IDLE.
  - `fetch_err` clears only on reset.
- `FETCH_TIMEOUT_EN` undefined: the unit waits for `mem_ack` indefinitely and `fetch_err` is tied 0.

## Structure
- Shared package `cpu_pkg`:
  - `INSTR_BYTES`=3.
  - Field slice constants: `OPC_HI`=23, `OPC_LO`=16, `ADR_HI`=15, `ADR_LO`=8, `OPD_HI`=7, `OPD_LO`=0.
  - `NOP_WORD`=24'h0.
  - Fetch FSM state enum.
- One sub-module, `fetch_watchdog`: wait counter plus timeout pulse, instantiated only under `FETCH_TIMEOUT_EN`.

## Test plan
- Reset, then memory holds 0x01,0x02,0x2A at 0x00–0x02 with zero-wait; `MAR_load` pulse, then `IR_load` at k+4 → `command_word`=24'h01022A, `mar`=0x00, `ir_pending` back to 0.
- `PC_inc`×2 from 0, then `PC_en`=1 with `PC_load`=0x40 and `PC_inc`=1 on the same edge → `pc`=0x06 then 0x40; `PC_inc` at `pc`=0xFE → 0x01.
- Fetch at `pc`=0xFE → `mem_addr` sequence 0xFE, 0xFF, 0x00.
- Memory asserts `mem_ack` only every third cycle → bytes captured correctly; `IR_load` held high throughout loads exactly once, after RD2; `command_word` then stable.
- Assert `rst` low after the RD1 capture → all outputs 0 at once; the next fetch from `pc`=0 is clean.
- With `FETCH_TIMEOUT_EN`: never assert `mem_ack` → after 16 wait cycles `fetch_err`=1, `ir_pending`=1, and `IR_load` gives `command_word`=24'h000000.
